// File: rtl/mac_dot_sequencer.sv
// Streams (W, I) operand pairs into an external MAC pipeline, rotating P partial-sum
// slots to cover the MAC latency, then reduces the slots into one dot-product result.
module mac_dot_sequencer #(
    parameter int DataInWidth         = 32,
    parameter int MUL_Pipeline_Stages = 5,
    parameter int LenWidth            = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LenWidth-1:0]    len,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DataInWidth-1:0] w_in,
    input  logic [DataInWidth-1:0] i_in,
    output logic                   mac_nop,
    output logic [DataInWidth-1:0] mac_w,
    output logic [DataInWidth-1:0] mac_i,
    output logic [DataInWidth-1:0] mac_o,
    input  logic                   mac_nop_out,
    input  logic [DataInWidth-1:0] mac_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DataInWidth-1:0] res_data
);

    localparam int P  = MUL_Pipeline_Stages + 1;
    localparam int SW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, REDUCE, DONE} state_t;

    state_t                 state, state_nx;
    logic [DataInWidth-1:0] slot [P];
    logic [P-1:0]           pending;
    logic [SW-1:0]          s_idx, r_idx, red_idx;
    logic [LenWidth-1:0]    len_q, count;
    logic [DataInWidth-1:0] acc;
    logic                   accept, ret_fire;

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
        return (v == SW'(P - 1)) ? '0 : v + 1'b1;
    endfunction

    assign busy     = (state != IDLE);
    assign in_ready = (state == ISSUE) && !pending[s_idx];
    assign accept   = in_ready && in_valid;
    // Returns come back in issue order, so r_idx always names the oldest outstanding slot.
    assign ret_fire = busy && !mac_nop_out && pending[r_idx];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = (len == '0) ? DONE : ISSUE;
            ISSUE:  if (accept && (count == len_q - 1'b1)) state_nx = DRAIN;
            DRAIN:  if (pending == '0) state_nx = REDUCE;
            REDUCE: if (red_idx == SW'(P - 1)) state_nx = DONE;
            DONE:   if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            s_idx     <= '0;
            r_idx     <= '0;
            red_idx   <= '0;
            len_q     <= '0;
            count     <= '0;
            acc       <= '0;
            mac_nop   <= 1'b1;
            mac_w     <= '0;
            mac_i     <= '0;
            mac_o     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            // NOTE: the slot array is reset explicitly; a mid-job reset must not leak
            // stale partial sums into the next job.
            for (int k = 0; k < P; k++) slot[k] <= '0;
        end else begin
            state <= state_nx;

            if (accept) begin
                mac_nop <= 1'b0;
                mac_w   <= w_in;
                mac_i   <= i_in;
                mac_o   <= slot[s_idx];
            end else begin
                mac_nop <= 1'b1;
            end

            if (ret_fire) begin
                slot[r_idx]    <= mac_data;
                pending[r_idx] <= 1'b0;
                r_idx          <= wrap_inc(r_idx);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        s_idx <= '0;
                        r_idx <= '0;
                        count <= '0;
                        if (len == '0) begin
                            res_data  <= '0;
                            res_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        pending[s_idx] <= 1'b1;
                        s_idx          <= wrap_inc(s_idx);
                        count          <= count + 1'b1;
                    end
                end
                DRAIN: begin
                    acc     <= '0;
                    red_idx <= '0;
                end
                REDUCE: begin
                    acc     <= acc + slot[red_idx];
                    red_idx <= wrap_inc(red_idx);
                    if (red_idx == SW'(P - 1)) begin
                        res_data  <= acc + slot[red_idx];
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        for (int k = 0; k < P; k++) slot[k] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer: a behavioural MAC pipeline feeds returns back,
// and a queue scoreboard holds each job's expected dot product until its handshake.
module tb_mac_dot_sequencer;

    localparam int DW = 32;
    localparam int L  = 5;
    localparam int LW = 16;
    localparam int P  = L + 1;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, res_ready;
    logic [LW-1:0] len;
    logic [DW-1:0] w_in, i_in;
    logic          busy, in_ready, mac_nop, mac_nop_out, res_valid;
    logic [DW-1:0] mac_w, mac_i, mac_o, mac_data, res_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nop0_cnt = 0;
    int nop_runs = 0;
    logic prev_nop = 1'b1;

    logic [DW-1:0] w_vec [16];
    logic [DW-1:0] i_vec [16];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    mac_dot_sequencer #(
        .DataInWidth(DW), .MUL_Pipeline_Stages(L), .LenWidth(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .w_in(w_in), .i_in(i_in),
        .mac_nop(mac_nop), .mac_w(mac_w), .mac_i(mac_i), .mac_o(mac_o),
        .mac_nop_out(mac_nop_out), .mac_data(mac_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // MAC model: the sequencer's registered mac_* outputs act as stage one, so L-1 more
    // stages follow. It is never reset, so in-flight ops survive a sequencer reset.
    logic [L-2:0]  m_nop = '1;
    logic [DW-1:0] m_dat [L-1] = '{default: '0};

    always @(posedge clk) begin
        m_nop    <= {m_nop[L-3:0], mac_nop};
        m_dat[0] <= mac_w * mac_i + mac_o;
        for (int k = 1; k < L - 1; k++) m_dat[k] <= m_dat[k-1];
    end
    assign mac_nop_out = m_nop[L-2];
    assign mac_data    = m_dat[L-2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mac_nop === 1'b0) begin
            nop0_cnt <= nop0_cnt + 1;
            if (prev_nop !== 1'b0) nop_runs <= nop_runs + 1;
        end
        prev_nop <= mac_nop;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"},      busy,      0);
        check({tag, " in_ready"},  in_ready,  0);
        check({tag, " mac_nop"},   mac_nop,   1);
        check({tag, " mac_w"},     mac_w,     0);
        check({tag, " mac_i"},     mac_i,     0);
        check({tag, " mac_o"},     mac_o,     0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_data"},  res_data,  0);
    endtask

    task automatic fill(input int n, input logic [DW-1:0] w, input logic [DW-1:0] i);
        for (int k = 0; k < n; k++) begin
            w_vec[k] = w;
            i_vec[k] = i;
        end
    endtask

    task automatic fill_t1();
        for (int k = 0; k < 4; k++) begin
            w_vec[k] = DW'(k + 1);
            i_vec[k] = DW'(k + 5);
        end
    endtask

    // gap: in_valid low on every gap-th feed cycle (0 = never); hold: cycles res_ready
    // stays low; abort_at: apply rst after that many accepts (0 = run to completion).
    task automatic run_job(input string tag, input int n, input int gap, input int hold,
                           input int abort_at, output int nop_delta, output int run_delta);
        logic [DW-1:0] exp_v, exp_pop;
        int  k, t, n0, r0, start_cyc, lat;
        logic fire;
        exp_v = '0;
        for (int j = 0; j < n; j++) exp_v += w_vec[j] * i_vec[j];
        if (abort_at == 0) exp_q.push_back(exp_v);
        n0 = nop0_cnt;
        r0 = nop_runs;

        @(negedge clk);
        start = 1'b1;
        len   = LW'(n);
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;

        k = 0;
        t = 0;
        while (k < n && t < 300) begin
            in_valid = !(gap != 0 && (t % gap) == gap - 1);
            w_in = w_vec[k];
            i_in = i_vec[k];
            #1 fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) k++;
            t++;
            @(negedge clk);
            if (abort_at != 0 && k == abort_at) break;
        end
        in_valid = 1'b0;

        if (abort_at != 0) begin
            check({tag, " accepts before reset"}, k, abort_at);
            rst = 1'b1;
            @(negedge clk);
            check_reset({tag, " reset"});
            rst = 1'b0;
            nop_delta = nop0_cnt - n0;
            run_delta = nop_runs - r0;
            return;
        end
        check({tag, " operands accepted"}, k, n);

        t = 0;
        while (res_valid !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        lat = cyc - start_cyc;
        check({tag, " res_valid"}, res_valid, 1);
        if (gap == 0) check({tag, " latency within bound"}, lat <= n + L + P + 3, 1);

        for (int h = 0; h < hold; h++) begin
            check({tag, " held valid"}, res_valid, 1);
            check({tag, " held data"}, res_data, (exp_q.size() > 0) ? exp_q[0] : 'x);
            if (h == 2) begin
                start = 1'b1;
                len   = LW'(4);
            end
            if (h == 4) start = 1'b0;
            @(negedge clk);
        end

        res_ready = 1'b1;
        exp_pop = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, " res_data"}, res_data, exp_pop);
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, " idle after handshake"}, busy, 0);
        check({tag, " res_valid dropped"}, res_valid, 0);
        nop_delta = nop0_cnt - n0;
        run_delta = nop_runs - r0;
    endtask

    initial begin
        int nd, rd;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        w_in = '0; i_in = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fill_t1();
        run_job("t1", 4, 0, 0, 0, nd, rd);
        check("t1 issue cycles", nd, 4);
        check("t1 issue bursts", rd, 1);

        run_job("t2", 0, 0, 0, 0, nd, rd);
        check("t2 issue cycles", nd, 0);

        fill(13, 32'd2, 32'd3);
        run_job("t3", 13, 3, 0, 0, nd, rd);
        check("t3 issue cycles", nd, 13);
        check("t3 issue bursts", rd, 7);

        fill(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_job("t4a", 2, 0, 0, 0, nd, rd);
        fill(1, 32'h0001_0000, 32'h0001_0000);
        run_job("t4b", 1, 0, 0, 0, nd, rd);

        fill_t1();
        run_job("t5", 4, 0, 10, 0, nd, rd);
        check("t5 issue cycles", nd, 4);

        run_job("t6 abort", 4, 0, 0, 3, nd, rd);
        repeat (8) @(negedge clk);
        check("t6 idle while stale returns drain", busy, 0);
        run_job("t6", 4, 0, 0, 0, nd, rd);
        check("t6 issue cycles", nd, 4);

        check("scoreboard empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
